// File: rtl/cpu_defs.sv
// cpu_defs: shared types and op decoding for the multiply/divide unit
package cpu_defs;
    typedef logic [31:0] uint32_t;
    typedef logic [63:0] uint64_t;
    localparam int DIV_ITER = 32;
    typedef enum logic [3:0] {
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
    } multdiv_op_t;
    function automatic logic op_signed(multdiv_op_t op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    endfunction
    function automatic logic op_div(multdiv_op_t op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction
endpackage

// File: rtl/divu_iter.sv
// divu_iter: 32-cycle unsigned restoring divider; done pulses one cycle after the last iteration
module divu_iter
    import cpu_defs::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start,
    input  uint32_t dividend,
    input  uint32_t divisor,
    output logic    done,
    output uint32_t quot,
    output uint32_t rem
);
    uint32_t d;
    logic [4:0] cnt;
    logic run;
    logic [32:0] shifted, diff;
    assign shifted = {rem, quot[31]};
    assign diff = shifted - {1'b0, d};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d <= '0;
            cnt <= '0;
            run <= 1'b0;
            done <= 1'b0;
            quot <= '0;
            rem <= '0;
        end else if (start) begin
            d <= divisor;
            cnt <= '0;
            run <= 1'b1;
            done <= 1'b0;
            quot <= dividend;
            rem <= '0;
        end else if (run) begin
            rem <= diff[32] ? shifted[31:0] : diff[31:0];
            quot <= {quot[30:0], ~diff[32]};
            cnt <= cnt + 5'd1;
            run <= cnt != 5'(DIV_ITER - 1);
            done <= cnt == 5'(DIV_ITER - 1);
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/multdiv.sv
// multdiv: multi-cycle MULT/DIV/MADD/MSUB unit producing one HI/LO write per accepted op
module multdiv
    import cpu_defs::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  multdiv_op_t req_op,
    input  uint32_t     req_a,
    input  uint32_t     req_b,
    input  uint64_t     hilo_rddata,
    output logic        busy,
    output logic        hilo_we,
    output uint64_t     hilo_wrdata
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state;
    logic [2:0] cnt;
    multdiv_op_t op_q;
    uint32_t a_q;
    uint64_t hilo_q;
    logic neg_q, neg_r, dz, we_q;
    logic accept, sa, sb, div_done;
    uint64_t ma, mb, mul_res, div_res;
    uint64_t pipe [MUL_CYCLES];
    uint32_t quot, rem;
    assign accept = req_valid & req_ready & ~flush;
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign hilo_we = we_q & ~flush;
    assign sa = op_signed(req_op) & req_a[31];
    assign sb = op_signed(req_op) & req_b[31];
    // sign-extended 64-bit operands give the exact low 64 bits of the 33x33 product
    assign ma = {{32{sa}}, req_a};
    assign mb = {{32{sb}}, req_b};
    assign mul_res = op_q inside {MD_MADD, MD_MADDU} ? hilo_q + pipe[MUL_CYCLES-1]
                   : op_q inside {MD_MSUB, MD_MSUBU} ? hilo_q - pipe[MUL_CYCLES-1]
                   : pipe[MUL_CYCLES-1];
    assign div_res = dz ? {a_q, 32'hFFFF_FFFF}
                   : {neg_r ? -rem : rem, neg_q ? -quot : quot};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_CYCLES; i++) pipe[i] <= '0;
        end else begin
            if (accept) pipe[0] <= ma * mb;
            for (int i = 1; i < MUL_CYCLES; i++) pipe[i] <= pipe[i-1];
        end
    end
    divu_iter u_div (
        .clk(clk),
        .rst_n(rst_n),
        .start(accept & op_div(req_op)),
        .dividend(sa ? -req_a : req_a),
        .divisor(sb ? -req_b : req_b),
        .done(div_done),
        .quot(quot),
        .rem(rem)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            op_q <= MD_MULT;
            a_q <= '0;
            hilo_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            we_q <= 1'b0;
            hilo_wrdata <= '0;
        end else if (flush) begin
            state <= IDLE;
            we_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    state <= op_div(req_op) ? DIV : MUL;
                    cnt <= '0;
                    op_q <= req_op;
                    a_q <= req_a;
                    hilo_q <= hilo_rddata;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    dz <= req_b == '0;
                end
                MUL: if (cnt == 3'(MUL_CYCLES - 1)) begin
                    state <= DONE;
                    hilo_wrdata <= mul_res;
                    we_q <= 1'b1;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                DIV: if (div_done) state <= FIX;
                FIX: begin
                    state <= DONE;
                    hilo_wrdata <= div_res;
                    we_q <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    we_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed checks of latency, results, flush and async reset for multdiv
module tb_multdiv;
    import cpu_defs::*;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, req_valid = 1'b0;
    multdiv_op_t req_op = MD_MULT;
    uint32_t req_a = '0, req_b = '0;
    uint64_t hilo_rddata = '0;
    logic req_ready, busy, hilo_we;
    uint64_t hilo_wrdata;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    multdiv #(.MUL_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .hilo_rddata(hilo_rddata), .busy(busy), .hilo_we(hilo_we), .hilo_wrdata(hilo_wrdata)
    );

    task automatic test_reset();
        #2;
        total++;
        if ({busy, hilo_we, req_ready} !== 3'b001) begin
            bad++; $display("FAIL reset_ctl got busy/we/ready=%b want 001", {busy, hilo_we, req_ready});
        end
        total++;
        if (hilo_wrdata !== 64'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0", hilo_wrdata);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic run_op(input multdiv_op_t op, input uint32_t a, input uint32_t b,
                          input uint64_t h, input int lat, input uint64_t exp, input string name);
        int k;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL %s_ready got=%b want=1", name, req_ready);
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; hilo_rddata = h;
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; hilo_rddata = {$urandom, $urandom};
        k = 0;
        while (hilo_we !== 1'b1 && k < 60) begin
            @(negedge clk); k++;
        end
        total++;
        if (k !== lat) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d", name, k, lat);
        end
        total++;
        if (hilo_wrdata !== exp) begin
            bad++; $display("FAIL %s_data got=%h want=%h", name, hilo_wrdata, exp);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s_busy_done got=%b want=1", name, busy);
        end
        @(negedge clk);
        total++;
        if ({busy, hilo_we, req_ready} !== 3'b001 || hilo_wrdata !== exp) begin
            bad++; $display("FAIL %s_after got busy/we/ready=%b data=%h want 001 data=%h",
                            name, {busy, hilo_we, req_ready}, hilo_wrdata, exp);
        end
    endtask

    task automatic test_mul();
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FFFA, "mult_neg");
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0, 3, 64'h0000_0002_FFFF_FFFA, "multu");
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 64'h0, 3, 64'h4000_0000_0000_0000, "mult_min");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 3, 64'hFFFF_FFFE_0000_0001, "multu_max");
    endtask

    task automatic test_madd_msub();
        run_op(MD_MADD,  32'd4, 32'd5, 64'h10, 3, 64'h24, "madd");
        run_op(MD_MSUBU, 32'd1, 32'd1, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FFFF, "msubu_wrap");
        run_op(MD_MSUB,  32'hFFFF_FFFF, 32'd2, 64'h100, 3, 64'h102, "msub_neg");
        run_op(MD_MADDU, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'h0, "maddu_wrap");
    endtask

    task automatic test_div();
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 64'h0, 34, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
        run_op(MD_DIVU, 32'd7, 32'd2, 64'h0, 34, 64'h0000_0001_0000_0003, "divu");
        run_op(MD_DIV,  32'd7, 32'hFFFF_FFFE, 64'h0, 34, 64'h0000_0001_FFFF_FFFD, "div_negb");
        run_op(MD_DIVU, 32'd100, 32'd7, 64'h0, 34, 64'h0000_0002_0000_000E, "divu_100_7");
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10, 64'h0, 34, 64'h0000_000F_0FFF_FFFF, "divu_big");
    endtask

    task automatic test_div_edge();
        run_op(MD_DIV,  32'h1234, 32'd0, 64'h0, 34, 64'h0000_1234_FFFF_FFFF, "div_zero");
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd0, 64'h0, 34, 64'hFFFF_FFF9_FFFF_FFFF, "div_zero_neg");
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd0, 64'h0, 34, 64'hFFFF_FFFF_FFFF_FFFF, "divu_zero");
        run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 34, 64'h0000_0000_8000_0000, "div_ovf");
    endtask

    task automatic test_flush_div();
        int wes, wk;
        uint64_t wd;
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd100; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0; wes = 0; wk = -1; wd = '0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (hilo_we === 1'b1) begin wes++; wk = k; wd = hilo_wrdata; end
            if (k == 10) flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL flush_busy got=%b want=0", busy);
                end
                req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd6; req_b = 32'd7;
            end
            if (k == 12) req_valid = 1'b0;
        end
        total++;
        if (wes !== 1 || wk !== 15) begin
            bad++; $display("FAIL flush_writes got count=%0d at=%0d want count=1 at=15", wes, wk);
        end
        total++;
        if (wd !== 64'd42) begin
            bad++; $display("FAIL flush_mult_data got=%h want=%h", wd, 64'd42);
        end
    endtask

    task automatic test_flush_done();
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd2; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0; k = 0;
        while (hilo_we !== 1'b1 && k < 10) begin
            @(negedge clk); k++;
        end
        total++;
        if (k !== 3) begin
            bad++; $display("FAIL flush_done_lat got=%0d want=3", k);
        end
        flush = 1'b1;
        #1;
        total++;
        if (hilo_we !== 1'b0) begin
            bad++; $display("FAIL flush_done_we got=%b want=0", hilo_we);
        end
        @(negedge clk);
        flush = 1'b0;
        total++;
        if ({busy, hilo_we} !== 2'b00) begin
            bad++; $display("FAIL flush_done_after got busy/we=%b want 00", {busy, hilo_we});
        end
        req_valid = 1'b1; flush = 1'b1; req_op = MD_MULT;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_accept got busy=%b want=0", busy);
        end
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) k++;
        end
        total++;
        if (k !== 0) begin
            bad++; $display("FAIL flush_idle_writes got=%0d want=0", k);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd5; req_b = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_busy_before got=%b want=1", busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, hilo_we} !== 2'b00 || hilo_wrdata !== 64'h0) begin
            bad++; $display("FAIL rst_mid_now got busy/we=%b data=%h want 00 data=0", {busy, hilo_we}, hilo_wrdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_ready got ready/busy=%b%b want 10", req_ready, busy);
        end
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) k++;
        end
        total++;
        if (k !== 0 || hilo_wrdata !== 64'h0) begin
            bad++; $display("FAIL rst_mid_nowrite got writes=%0d data=%h want 0 data=0", k, hilo_wrdata);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_madd_msub();
        test_div();
        test_div_edge();
        test_flush_div();
        test_flush_done();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
